// File: rtl/flash_seg_loader.sv
// flash_seg_loader: boot-time copier that walks a multi-segment image header in
// flash and copies every segment payload into SRAM at its destination address.
// Optional feature macro: FLASH_SEG_LOADER_CHECKSUM_EN (adds payload checksum
// verification through an extra RD_CHK state before FINISH).
module flash_seg_loader #(
    parameter int DATA_W   = 32,
    parameter int FLASH_AW = 25,
    parameter int SRAM_AW  = 22,
    parameter int MAX_SEGS = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                flash_ready,
    input  logic [DATA_W-1:0]   flash_data,
    output logic [FLASH_AW-1:0] flash_addr,
    output logic                flash_cs,
    input  logic                sram_ready,
    output logic [DATA_W-1:0]   sram_data,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic                sram_cs,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code,
    output logic [31:0]         words_copied
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_CNT,
        S_RD_DST,
        S_RD_SIZE,
        S_CP_RD,
        S_CP_WR,
        S_NEXT_SEG,
`ifdef FLASH_SEG_LOADER_CHECKSUM_EN
        S_RD_CHK,
`endif
        S_FINISH,
        S_DONE,
        S_ERR
    } state_t;

    // Sub-phases of one flash read: request pulse, fixed latency, data capture.
    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_WAIT,
        PH_CAP
    } phase_t;

    localparam int WCW = $clog2(WAIT_CYC + 1);
    localparam logic [WCW-1:0]    WAIT_LAST  = WCW'(WAIT_CYC - 1);
    localparam logic [DATA_W-1:0] MAX_SEGS_W = DATA_W'(MAX_SEGS);
`ifdef FLASH_SEG_LOADER_CHECKSUM_EN
    localparam state_t AFTER_SEGS = S_RD_CHK;
`else
    localparam state_t AFTER_SEGS = S_FINISH;
`endif

    state_t                state, state_n;
    phase_t                phase, phase_n;
    logic [WCW-1:0]        wait_cnt, wait_cnt_n;
    logic [FLASH_AW-1:0]   hdr_ptr, hdr_ptr_n;
    logic [FLASH_AW-1:0]   pay_ptr, pay_ptr_n;
    logic [DATA_W-1:0]     seg_total, seg_total_n;
    logic [31:0]           seg_idx, seg_idx_n;
    logic [SRAM_AW-1:0]    dst, dst_n;
    logic [31:0]           seg_size, seg_size_n;
    logic [31:0]           cnt, cnt_n;
    logic [DATA_W-1:0]     word_q, word_q_n;
    logic [31:0]           words_n;
    logic [1:0]            err_code_n;
    logic                  rd_active;
    logic                  rd_done;
`ifdef FLASH_SEG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]     sum, sum_n;
`endif

    assign busy  = !(state == S_IDLE || state == S_DONE || state == S_ERR);
    assign done  = (state == S_DONE);
    assign error = (state == S_ERR);

    // Select which flash word the current state reads, if any.
    always_comb begin
        rd_active  = 1'b0;
        flash_addr = '0;
        case (state)
            S_RD_CNT: begin
                rd_active  = 1'b1;
                flash_addr = '0;
            end
            S_RD_DST, S_RD_SIZE: begin
                rd_active  = 1'b1;
                flash_addr = hdr_ptr;
            end
            S_CP_RD: begin
                rd_active  = 1'b1;
                flash_addr = pay_ptr;
            end
`ifdef FLASH_SEG_LOADER_CHECKSUM_EN
            S_RD_CHK: begin
                rd_active  = 1'b1;
                flash_addr = pay_ptr;
            end
`endif
            default: ;
        endcase
    end

    // Flash read handshake: one-cycle cs when ready, fixed wait, capture on ready.
    always_comb begin
        phase_n    = phase;
        wait_cnt_n = wait_cnt;
        flash_cs   = 1'b0;
        rd_done    = 1'b0;
        if (rd_active) begin
            case (phase)
                PH_ISSUE: begin
                    if (flash_ready) begin
                        flash_cs   = 1'b1;
                        phase_n    = PH_WAIT;
                        wait_cnt_n = '0;
                    end
                end
                PH_WAIT: begin
                    if (wait_cnt == WAIT_LAST) phase_n = PH_CAP;
                    else wait_cnt_n = wait_cnt + WCW'(1);
                end
                PH_CAP: begin
                    if (flash_ready) begin
                        rd_done = 1'b1;
                        phase_n = PH_ISSUE;
                    end
                end
                default: phase_n = PH_ISSUE;
            endcase
        end
    end

    // Header walk, payload copy and completion sequencing.
    always_comb begin
        state_n     = state;
        hdr_ptr_n   = hdr_ptr;
        pay_ptr_n   = pay_ptr;
        seg_total_n = seg_total;
        seg_idx_n   = seg_idx;
        dst_n       = dst;
        seg_size_n  = seg_size;
        cnt_n       = cnt;
        word_q_n    = word_q;
        words_n     = words_copied;
        err_code_n  = err_code;
`ifdef FLASH_SEG_LOADER_CHECKSUM_EN
        sum_n       = sum;
`endif
        sram_cs     = 1'b0;
        sram_addr   = '0;
        sram_data   = '0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_n    = S_RD_CNT;
                    words_n    = '0;
                    err_code_n = 2'd0;
                    seg_idx_n  = '0;
`ifdef FLASH_SEG_LOADER_CHECKSUM_EN
                    sum_n      = '0;
`endif
                end
            end
            S_RD_CNT: begin
                if (rd_done) begin
                    seg_total_n = flash_data;
                    seg_idx_n   = '0;
                    if (flash_data == '0) begin
                        // Empty image: checksum word (if any) sits right after word 0.
                        pay_ptr_n = FLASH_AW'(1);
                        state_n   = AFTER_SEGS;
                    end else if (flash_data > MAX_SEGS_W) begin
                        err_code_n = 2'd1;
                        state_n    = S_ERR;
                    end else begin
                        hdr_ptr_n = FLASH_AW'(1);
                        pay_ptr_n = FLASH_AW'({flash_data, 1'b1});
                        state_n   = S_RD_DST;
                    end
                end
            end
            S_RD_DST: begin
                if (rd_done) begin
                    dst_n     = flash_data[SRAM_AW-1:0];
                    hdr_ptr_n = hdr_ptr + FLASH_AW'(1);
                    state_n   = S_RD_SIZE;
                end
            end
            S_RD_SIZE: begin
                if (rd_done) begin
                    seg_size_n = 32'(flash_data);
                    hdr_ptr_n  = hdr_ptr + FLASH_AW'(1);
                    cnt_n      = '0;
                    state_n    = (32'(flash_data) == 32'd0) ? S_NEXT_SEG : S_CP_RD;
                end
            end
            S_CP_RD: begin
                if (rd_done) begin
                    word_q_n = flash_data;
`ifdef FLASH_SEG_LOADER_CHECKSUM_EN
                    sum_n    = sum + flash_data;
`endif
                    state_n  = S_CP_WR;
                end
            end
            S_CP_WR: begin
                sram_addr = dst + cnt[SRAM_AW-1:0];
                sram_data = word_q;
                if (sram_ready) begin
                    sram_cs   = 1'b1;
                    pay_ptr_n = pay_ptr + FLASH_AW'(1);
                    cnt_n     = cnt + 32'd1;
                    words_n   = words_copied + 32'd1;
                    state_n   = ((cnt + 32'd1) == seg_size) ? S_NEXT_SEG : S_CP_RD;
                end
            end
            S_NEXT_SEG: begin
                seg_idx_n = seg_idx + 32'd1;
                state_n   = ((seg_idx + 32'd1) == 32'(seg_total)) ? AFTER_SEGS : S_RD_DST;
            end
`ifdef FLASH_SEG_LOADER_CHECKSUM_EN
            S_RD_CHK: begin
                if (rd_done) begin
                    if (flash_data == sum) begin
                        state_n = S_FINISH;
                    end else begin
                        err_code_n = 2'd2;
                        state_n    = S_ERR;
                    end
                end
            end
`endif
            S_FINISH: begin
                if (sram_ready) state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, pointer and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            phase        <= PH_ISSUE;
            wait_cnt     <= '0;
            hdr_ptr      <= '0;
            pay_ptr      <= '0;
            seg_total    <= '0;
            seg_idx      <= '0;
            dst          <= '0;
            seg_size     <= '0;
            cnt          <= '0;
            word_q       <= '0;
            words_copied <= '0;
            err_code     <= '0;
`ifdef FLASH_SEG_LOADER_CHECKSUM_EN
            sum          <= '0;
`endif
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            wait_cnt     <= wait_cnt_n;
            hdr_ptr      <= hdr_ptr_n;
            pay_ptr      <= pay_ptr_n;
            seg_total    <= seg_total_n;
            seg_idx      <= seg_idx_n;
            dst          <= dst_n;
            seg_size     <= seg_size_n;
            cnt          <= cnt_n;
            word_q       <= word_q_n;
            words_copied <= words_n;
            err_code     <= err_code_n;
`ifdef FLASH_SEG_LOADER_CHECKSUM_EN
            sum          <= sum_n;
`endif
        end
    end

endmodule

// File: tb/tb_flash_seg_loader.sv
// Bench for flash_seg_loader: table of image scenarios with hand-computed SRAM
// writes, plus hand-written reset-abort and (when enabled) checksum sequences.
module tb_flash_seg_loader;

    localparam int DATA_W   = 32;
    localparam int FLASH_AW = 25;
    localparam int SRAM_AW  = 22;
    localparam int MAX_SEGS = 8;
    localparam int WAIT_CYC = 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                flash_ready = 1'b1;
    logic [DATA_W-1:0]   flash_data;
    logic [FLASH_AW-1:0] flash_addr;
    logic                flash_cs;
    logic                sram_ready = 1'b1;
    logic [DATA_W-1:0]   sram_data;
    logic [SRAM_AW-1:0]  sram_addr;
    logic                sram_cs;
    logic                busy;
    logic                done;
    logic                error;
    logic [1:0]          err_code;
    logic [31:0]         words_copied;

    flash_seg_loader #(
        .DATA_W(DATA_W), .FLASH_AW(FLASH_AW), .SRAM_AW(SRAM_AW),
        .MAX_SEGS(MAX_SEGS), .WAIT_CYC(WAIT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .flash_ready(flash_ready), .flash_data(flash_data),
        .flash_addr(flash_addr), .flash_cs(flash_cs),
        .sram_ready(sram_ready), .sram_data(sram_data),
        .sram_addr(sram_addr), .sram_cs(sram_cs),
        .busy(busy), .done(done), .error(error),
        .err_code(err_code), .words_copied(words_copied)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       n;
        logic [3:0][31:0]  dst;
        logic [3:0][31:0]  sz;
        logic [7:0][31:0]  pay;
        bit                stall;
        bit                exp_done;
        bit                exp_err;
        logic [1:0]        exp_code;
        logic [31:0]       exp_words;
        int                exp_nwr;
        logic [7:0][21:0]  exp_wa;
        logic [7:0][31:0]  exp_wd;
    } vec_t;

    // Flash image and observed SRAM write log
    logic [31:0] flash_mem [0:63];
    logic [5:0]  rd_addr = '0;
    logic [21:0] wr_a [0:127];
    logic [31:0] wr_d [0:127];
    int          nwr = 0;
    int          cs_count = 0;
    int          proto_viol = 0;
    int          fl_hold = 0;
    int          sr_hold = 0;
    bit          stall_en = 1'b0;
    bit          sram_block = 1'b0;
    bit          prev_fcs = 1'b0;
    bit          prev_scs = 1'b0;

    int checks = 0;
    int errors = 0;

    assign flash_data = flash_mem[rd_addr];

    // Flash/SRAM controller models: drive ready at negedge, then observe cs.
    initial begin
        forever begin
            @(negedge clk);
            flash_ready = !(stall_en && fl_hold > 0);
            sram_ready  = !(sram_block || (stall_en && sr_hold > 0));
            if (fl_hold > 0) fl_hold--;
            if (sr_hold > 0) sr_hold--;
            #1;
            if (flash_cs) begin
                rd_addr = flash_addr[5:0];
                cs_count++;
                if (!flash_ready || prev_fcs || sram_cs) proto_viol++;
                fl_hold = int'($urandom_range(5, 1));
            end
            if (sram_cs) begin
                if (nwr < 128) begin
                    wr_a[nwr] = sram_addr;
                    wr_d[nwr] = sram_data;
                end
                nwr++;
                cs_count++;
                if (!sram_ready || prev_scs) proto_viol++;
                sr_hold = int'($urandom_range(5, 1));
            end
            prev_fcs = flash_cs;
            prev_scs = sram_cs;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_image(input vec_t v, output int chk_at);
        int pos;
        int pi;
        logic [31:0] sum;
        for (int i = 0; i < 64; i++) flash_mem[i] = '0;
        flash_mem[0] = v.n;
        sum = '0;
        chk_at = 1;
        if (v.n <= 32'(MAX_SEGS)) begin
            for (int k = 0; k < int'(v.n) && k < 4; k++) begin
                flash_mem[1 + 2 * k] = v.dst[k];
                flash_mem[2 + 2 * k] = v.sz[k];
            end
            pos = 1 + 2 * int'(v.n);
            pi  = 0;
            for (int k = 0; k < int'(v.n) && k < 4; k++) begin
                for (int j = 0; j < int'(v.sz[k]); j++) begin
                    flash_mem[pos] = v.pay[pi];
                    sum = sum + v.pay[pi];
                    pos++;
                    pi++;
                end
            end
            flash_mem[pos] = sum;
            chk_at = pos;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx, input bit corrupt);
        int chk_at;
        int base;
        int vbase;
        int cyc;
        load_image(v, chk_at);
        if (corrupt) flash_mem[chk_at] = flash_mem[chk_at] ^ 32'h1;
        stall_en = v.stall;
        base  = nwr;
        vbase = proto_viol;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        check($sformatf("v%0d_busy_after_start", idx), 32'(busy), 32'd1);
        cyc = 0;
        while (!(done || error) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        #2;
        check($sformatf("v%0d_finished_in_time", idx), 32'(cyc < 3000), 32'd1);
        check($sformatf("v%0d_done", idx), 32'(done), 32'(v.exp_done));
        check($sformatf("v%0d_error", idx), 32'(error), 32'(v.exp_err));
        check($sformatf("v%0d_err_code", idx), 32'(err_code), 32'(v.exp_code));
        check($sformatf("v%0d_words_copied", idx), words_copied, v.exp_words);
        check($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d_sram_writes", idx), 32'(nwr - base), 32'(v.exp_nwr));
        for (int w = 0; w < v.exp_nwr && w < 8; w++) begin
            check($sformatf("v%0d_wr%0d_addr", idx, w), 32'(wr_a[base + w]), 32'(v.exp_wa[w]));
            check($sformatf("v%0d_wr%0d_data", idx, w), wr_d[base + w], v.exp_wd[w]);
        end
        check($sformatf("v%0d_cs_protocol", idx), 32'(proto_viol - vbase), 32'd0);
        stall_en = 1'b0;
    endtask

    vec_t vecs [0:6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cyc;
        int cs_before;
        vec_t vc;

        for (int i = 0; i < 7; i++) vecs[i] = '{default: '0};

        // Two segments, payload A,B,C then D
        vecs[0].n = 32'd2;
        vecs[0].dst[0] = 32'h100;  vecs[0].sz[0] = 32'd3;
        vecs[0].dst[1] = 32'h2000; vecs[0].sz[1] = 32'd1;
        vecs[0].pay[0] = 32'hDEAD0001; vecs[0].pay[1] = 32'hDEAD0002;
        vecs[0].pay[2] = 32'hDEAD0003; vecs[0].pay[3] = 32'hBEEF0004;
        vecs[0].exp_done = 1'b1; vecs[0].exp_words = 32'd4; vecs[0].exp_nwr = 4;
        vecs[0].exp_wa[0] = 22'h100;  vecs[0].exp_wd[0] = 32'hDEAD0001;
        vecs[0].exp_wa[1] = 22'h101;  vecs[0].exp_wd[1] = 32'hDEAD0002;
        vecs[0].exp_wa[2] = 22'h102;  vecs[0].exp_wd[2] = 32'hDEAD0003;
        vecs[0].exp_wa[3] = 22'h2000; vecs[0].exp_wd[3] = 32'hBEEF0004;
        // Empty image
        vecs[1].n = 32'd0;
        vecs[1].exp_done = 1'b1;
        // Segment count above the limit
        vecs[2].n = 32'd9;
        vecs[2].exp_err = 1'b1; vecs[2].exp_code = 2'd1;
        // SRAM address wrap and a zero-size middle segment
        vecs[3].n = 32'd3;
        vecs[3].dst[0] = 32'h3FFFFF; vecs[3].sz[0] = 32'd2;
        vecs[3].dst[1] = 32'h500;    vecs[3].sz[1] = 32'd0;
        vecs[3].dst[2] = 32'h10;     vecs[3].sz[2] = 32'd1;
        vecs[3].pay[0] = 32'h11111111; vecs[3].pay[1] = 32'h22222222;
        vecs[3].pay[2] = 32'h33333333;
        vecs[3].exp_done = 1'b1; vecs[3].exp_words = 32'd3; vecs[3].exp_nwr = 3;
        vecs[3].exp_wa[0] = 22'h3FFFFF; vecs[3].exp_wd[0] = 32'h11111111;
        vecs[3].exp_wa[1] = 22'h000000; vecs[3].exp_wd[1] = 32'h22222222;
        vecs[3].exp_wa[2] = 22'h000010; vecs[3].exp_wd[2] = 32'h33333333;
        // First image again with both readies stalling after every access
        vecs[4] = vecs[0];
        vecs[4].stall = 1'b1;
        // Largest legal count, all segments empty
        vecs[5].n = 32'd8;
        vecs[5].exp_done = 1'b1;
        // Single all-ones word under stalls
        vecs[6].n = 32'd1;
        vecs[6].dst[0] = 32'h40; vecs[6].sz[0] = 32'd1;
        vecs[6].pay[0] = 32'hFFFFFFFF;
        vecs[6].stall = 1'b1;
        vecs[6].exp_done = 1'b1; vecs[6].exp_words = 32'd1; vecs[6].exp_nwr = 1;
        vecs[6].exp_wa[0] = 22'h40; vecs[6].exp_wd[0] = 32'hFFFFFFFF;

        for (int i = 0; i < 64; i++) flash_mem[i] = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_words", words_copied, 32'd0);
        check("rst_cs", 32'({flash_cs, sram_cs}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("idle_no_cs", 32'(cs_count), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i, 1'b0);

        // Reset while the third payload word waits for SRAM
        load_image(vecs[0], cyc);
        base = nwr;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while ((nwr - base) < 2 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        sram_block = 1'b1;
        repeat (12) @(negedge clk);
        #2;
        check("abort_two_writes_seen", 32'(nwr - base), 32'd2);
        check("abort_pre_busy", 32'(busy), 32'd1);
        check("abort_pre_words", words_copied, 32'd2);
        cs_before = cs_count;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done_error", 32'({done, error}), 32'd0);
        check("abort_words", words_copied, 32'd0);
        check("abort_err_code", 32'(err_code), 32'd0);
        repeat (3) @(negedge clk);
        sram_block = 1'b0;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        check("abort_no_cs_after", 32'(cs_count - cs_before), 32'd0);
        check("abort_no_more_writes", 32'(nwr - base), 32'd2);
        check("abort_outputs_idle", 32'({flash_cs, sram_cs, busy}), 32'd0);
        run_vec(vecs[0], 10, 1'b0);

`ifdef FLASH_SEG_LOADER_CHECKSUM_EN
        // Corrupted checksum word: all payload written, then abort with code 2
        vc = vecs[0];
        vc.exp_done = 1'b0;
        vc.exp_err  = 1'b1;
        vc.exp_code = 2'd2;
        run_vec(vc, 11, 1'b1);
`else
        vc = vecs[0];
`endif
        // Restart from whatever end state the previous run left
        run_vec(vc.exp_err ? vecs[0] : vecs[3], 12, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
